// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the GPIO APB arbiter: FSM state encoding and the
// register map of the GPIO slave it drives.
package gpio_apb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } apb_state_t;

    // GPIO slave register map.
    localparam logic [7:0] GPIO_PSL = 8'h00;  // pin select (write)
    localparam logic [7:0] GPIO_DIR = 8'h04;  // direction (write)
    localparam logic [7:0] GPIO_SET = 8'h08;  // set output bits (write)
    localparam logic [7:0] GPIO_CLR = 8'h0C;  // clear output bits (write)
    localparam logic [7:0] GPIO_IN  = 8'h10;  // input pins (read)

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. The requester that was not granted last wins a
// tie; a lone requester always wins. The pointer moves only when the caller
// accepts the pick.
module rr_arbiter2 (
    input  logic       PCLK,
    input  logic       PRESETn,   // synchronous, active-high
    input  logic [1:0] req,
    input  logic       advance,   // pick accepted this cycle
    output logic       valid,
    output logic       sel        // 0 = requester 0, 1 = requester 1
);

    logic last_q;  // index of the requester granted most recently

    // Pick a winner from the current requests and the last-granted pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = |req;
        sel   = 1'b0;
        if (req == 2'b11) begin
            sel = ~last_q;
        end else begin
            sel = req[1];
        end
    end

    // Remember who was granted; reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (PRESETn) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= sel;
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Arbitrates two command requesters onto a single APB master port toward a
// GPIO slave. Legal commands run a SETUP/ACCESS transfer; illegal ones are
// rejected through a one-cycle ERR state without touching the bus.
module gpio_apb_arbiter
    import gpio_apb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,   // synchronous, active-high despite the name
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWrite,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t        state_q, state_d;
    logic              owner_q;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;

    logic              arb_valid;
    logic              arb_sel;
    logic              load;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Writes go to the four control registers, reads only to the input register.
    function automatic logic cmd_legal(input logic wr, input logic [ADDR_W-1:0] addr);
        if (wr) begin
            return (addr == ADDR_W'(GPIO_PSL)) || (addr == ADDR_W'(GPIO_DIR)) ||
                   (addr == ADDR_W'(GPIO_SET)) || (addr == ADDR_W'(GPIO_CLR));
        end
        return addr == ADDR_W'(GPIO_IN);
    endfunction

    rr_arbiter2 u_rr (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     ({req1, req0}),
        .advance (load),
        .valid   (arb_valid),
        .sel     (arb_sel)
    );

    assign sel_wr    = arb_sel ? wr1    : wr0;
    assign sel_addr  = arb_sel ? addr1  : addr0;
    assign sel_wdata = arb_sel ? wdata1 : wdata0;

    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign err   = err_q;
    assign rdata = rdata_q;

    // Next-state logic plus bus and grant outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_d  = 2'b00;
        err_d   = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWrite  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    load    = 1'b1;
                    state_d = cmd_legal(sel_wr, sel_addr) ? ST_SETUP : ST_ERR;
                end
            end
            ST_SETUP: begin
                gnt0    = ~owner_q;
                gnt1    = owner_q;
                PSEL    = 1'b1;
                PWrite  = cmd_wr_q;
                PADDR   = cmd_addr_q;
                PWDATA  = cmd_wdata_q;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWrite  = cmd_wr_q;
                PADDR   = cmd_addr_q;
                PWDATA  = cmd_wdata_q;
                done_d  = owner_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                gnt0    = ~owner_q;
                gnt1    = owner_q;
                done_d  = owner_q ? 2'b10 : 2'b01;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winning command, register done/err pulses and capture read data.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            owner_q     <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (load) begin
                owner_q     <= arb_sel;
                cmd_wr_q    <= sel_wr;
                cmd_addr_q  <= sel_addr;
                // Reads carry zero write data so PWDATA stays 0 on read transfers.
                cmd_wdata_q <= sel_wr ? sel_wdata : '0;
            end
            if (state_q == ST_ACCESS && !cmd_wr_q) begin
                rdata_q <= PRDATA;
            end
        end
    end

endmodule
